// File: rtl/barcode_packer_if.sv
// Byte-in / word-out bus of the barcode packer: upstream byte handshake plus
// the downstream word-memory write port and frame status.
interface barcode_packer_if #(
  parameter int ADDR_W = 11
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic              frame_done;
  logic [ADDR_W-1:0] word_count;
  logic              overflow;

  modport master (
    output in_valid, in_byte, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, frame_done, word_count, overflow
  );

  modport slave (
    input  in_valid, in_byte, in_last,
    output in_ready, wr_en, wr_addr, wr_data, frame_done, word_count, overflow
  );
endinterface

// File: rtl/barcode_packer.sv
// Packs a frame of barcode bytes MSB-first into 128-bit words for a DEPTH-word memory.
// Optional PACKER_CHECKSUM_EN adds an XOR checksum output of the frame's bytes.
module barcode_packer #(
  parameter int DEPTH  = 1958,
  parameter int ADDR_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  barcode_packer_if.slave  bus
`ifdef PACKER_CHECKSUM_EN
  ,
  output logic [7:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t       state;
  logic [3:0]   bidx;
  logic [127:0] word_p0;
  logic [127:0] word_nx;
  logic [127:0] wr_word;
  logic         accept;
  logic         do_write;
  logic         full;

  // Starting a word (index 0) drops the previous contents so a flushed word is zero-padded.
  function automatic logic [127:0] place_byte(input logic [127:0] cur,
                                              input logic [3:0]   idx,
                                              input logic [7:0]   b);
    logic [127:0] w;
    w = (idx == 4'd0) ? '0 : cur;
    w[8*(15-int'(idx)) +: 8] = b;
    return w;
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign word_nx  = place_byte(word_p0, bidx, bus.in_byte);
  assign full     = ({1'b0, bus.word_count} >= DEPTH_W);
  assign do_write = (accept && (bidx == 4'd15)) || (state == FLUSH);
  assign wr_word  = (state == FLUSH) ? word_p0 : word_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bidx           <= 4'd0;
      word_p0        <= '0;
      bus.in_ready   <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.frame_done <= 1'b0;
      bus.word_count <= '0;
      bus.overflow   <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      checksum       <= 8'h00;
`endif
    end else begin
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;

      // Word commit stage: a full or flushed word goes out next cycle unless memory is full.
      if (do_write) begin
        if (full) begin
          bus.overflow <= 1'b1;
        end else begin
          bus.wr_en      <= 1'b1;
          bus.wr_addr    <= bus.word_count;
          bus.wr_data    <= wr_word;
          bus.word_count <= bus.word_count + ONE;
        end
      end

      case (state)
        IDLE, PACK: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            word_p0 <= word_nx;
            bidx    <= bidx + 4'd1;
            if (state == IDLE) begin
              bus.word_count <= '0;
              bus.overflow   <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
              checksum       <= bus.in_byte;
`endif
            end else begin
`ifdef PACKER_CHECKSUM_EN
              checksum       <= checksum ^ bus.in_byte;
`endif
            end
            if (bus.in_last) begin
              bidx         <= 4'd0;
              bus.in_ready <= 1'b0;
              state        <= (bidx == 4'd15) ? DONE : FLUSH;
            end else begin
              state        <= PACK;
            end
          end
        end
        FLUSH: begin
          state <= DONE;
        end
        DONE: begin
          state          <= IDLE;
          bus.frame_done <= 1'b1;
          bus.in_ready   <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
